// File: rtl/riscv_mem_arb_pkg.sv
// Shared definitions for the fetch/LSU memory arbiter: source encodings,
// arbitration FSM state encodings and the round-robin pick helper.
package riscv_mem_arb_pkg;

    // Request/response source carried in each outstanding FIFO entry
    localparam logic SRC_I = 1'b0;
    localparam logic SRC_D = 1'b1;

    // Arbitration FSM states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // Pick the side to grant: a lone requester always wins, a contested
    // cycle goes to whichever side the round-robin pointer currently favours.
    function automatic logic rr_pick(input logic i_req, input logic d_req, input logic rr_ptr);
        logic src;
        if (i_req && d_req) begin
            src = rr_ptr;
        end else if (d_req) begin
            src = SRC_D;
        end else begin
            src = SRC_I;
        end
        return src;
    endfunction

endpackage

// File: rtl/riscv_mem_arb_if.sv
// Bus bundle between the core's fetch/LSU ports, the arbiter and the
// downstream memory bridge. The slave modport is the arbiter's view; the
// master modport is the view of whatever surrounds it (core + memory).
interface riscv_mem_arb_if #(
    parameter int TAG_W = 11
);
    // Instruction-fetch port
    logic              i_rd_i;
    logic [31:0]       i_pc_i;
    logic              i_accept_o;
    logic              i_valid_o;
    logic              i_error_o;
    logic [31:0]       i_inst_o;

    // LSU data port
    logic [31:0]       d_addr_i;
    logic [31:0]       d_data_wr_i;
    logic              d_rd_i;
    logic [3:0]        d_wr_i;
    logic [TAG_W-1:0]  d_req_tag_i;
    logic              d_flush_i;
    logic              d_accept_o;
    logic              d_ack_o;
    logic              d_error_o;
    logic [31:0]       d_data_rd_o;
    logic [TAG_W-1:0]  d_resp_tag_o;

    // Downstream memory port
    logic [31:0]       mem_addr_o;
    logic [31:0]       mem_data_wr_o;
    logic              mem_rd_o;
    logic [3:0]        mem_wr_o;
    logic              mem_accept_i;
    logic              mem_ack_i;
    logic              mem_error_i;
    logic [31:0]       mem_data_rd_i;

    modport slave (
        input  i_rd_i, i_pc_i,
        output i_accept_o, i_valid_o, i_error_o, i_inst_o,
        input  d_addr_i, d_data_wr_i, d_rd_i, d_wr_i, d_req_tag_i, d_flush_i,
        output d_accept_o, d_ack_o, d_error_o, d_data_rd_o, d_resp_tag_o,
        output mem_addr_o, mem_data_wr_o, mem_rd_o, mem_wr_o,
        input  mem_accept_i, mem_ack_i, mem_error_i, mem_data_rd_i
    );

    modport master (
        output i_rd_i, i_pc_i,
        input  i_accept_o, i_valid_o, i_error_o, i_inst_o,
        output d_addr_i, d_data_wr_i, d_rd_i, d_wr_i, d_req_tag_i, d_flush_i,
        input  d_accept_o, d_ack_o, d_error_o, d_data_rd_o, d_resp_tag_o,
        input  mem_addr_o, mem_data_wr_o, mem_rd_o, mem_wr_o,
        output mem_accept_i, mem_ack_i, mem_error_i, mem_data_rd_i
    );

endinterface

// File: rtl/riscv_mem_arb_fifo.sv
// Synchronous FIFO holding {src, tag} for every request the downstream port
// has accepted but not yet acknowledged. Head entry is read combinationally.
module riscv_mem_arb_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Pointer advance; for power-of-two depths this is the natural wrap.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = store[rd_ptr];

    // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are meaningless while not counted, so no reset
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            store[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/riscv_mem_arb.sv
// Shares one downstream memory port between instruction fetch and the LSU.
// Round-robin arbitration with the grant locked until the downstream accepts,
// in-order response routing through an outstanding FIFO, and local completion
// of LSU flush requests without any downstream traffic.
module riscv_mem_arb
    import riscv_mem_arb_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int TAG_W       = 11
) (
    input  logic            clk_i,
    input  logic            rst_i,
    riscv_mem_arb_if.slave  bus
);

    logic             i_req;
    logic             d_req;
    logic             both_req;

    logic [1:0]       state_q;
    logic             grant_src_q;
    logic             rr_q;

    logic             sel_src;
    logic             issue;
    logic             flush_take;
    logic             mem_accepted;

    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic [TAG_W:0]   push_entry;
    logic [TAG_W:0]   head_entry;
    logic             head_src;
    logic [TAG_W-1:0] head_tag;

    logic [31:0]      mem_addr;
    logic [31:0]      mem_data_wr;
    logic             mem_rd;
    logic [3:0]       mem_wr;

    logic             i_valid_q;
    logic             i_error_q;
    logic [31:0]      i_inst_q;
    logic             d_ack_q;
    logic             d_error_q;
    logic [31:0]      d_data_rd_q;
    logic [TAG_W-1:0] d_resp_tag_q;

    assign i_req    = bus.i_rd_i;
    assign d_req    = bus.d_rd_i || (bus.d_wr_i != 4'b0000);
    assign both_req = i_req && d_req;

    // Decide who owns the downstream port this cycle. In HOLD the earlier grant
    // is kept regardless of the other side. A flush wins over a fetch in the
    // same cycle so that FLUSH never has to coexist with a pending grant.
    always_comb begin
        sel_src    = SRC_I;
        issue      = 1'b0;
        flush_take = 1'b0;
        case (state_q)
            ST_HOLD: begin
                sel_src = grant_src_q;
                issue   = 1'b1;
            end
            ST_IDLE: begin
                flush_take = bus.d_flush_i && fifo_empty && !d_req;
                sel_src    = rr_pick(i_req, d_req, rr_q);
                issue      = (i_req || d_req) && !fifo_full && !flush_take;
            end
            default: begin
                sel_src = SRC_I;
            end
        endcase
    end

    // Route the granted side onto the downstream port; idle port is all zero
    always_comb begin
        mem_addr    = 32'h0;
        mem_data_wr = 32'h0;
        mem_rd      = 1'b0;
        mem_wr      = 4'b0000;
        if (issue) begin
            if (sel_src == SRC_D) begin
                mem_addr    = bus.d_addr_i;
                mem_data_wr = bus.d_data_wr_i;
                mem_rd      = bus.d_rd_i;
                mem_wr      = bus.d_wr_i;
            end else begin
                mem_addr = bus.i_pc_i;
                mem_rd   = 1'b1;
            end
        end
    end

    assign mem_accepted      = issue && bus.mem_accept_i;
    assign bus.mem_addr_o    = mem_addr;
    assign bus.mem_data_wr_o = mem_data_wr;
    assign bus.mem_rd_o      = mem_rd;
    assign bus.mem_wr_o      = mem_wr;
    assign bus.i_accept_o    = mem_accepted && (sel_src == SRC_I);
    assign bus.d_accept_o    = (mem_accepted && (sel_src == SRC_D)) || flush_take;

    // Fetch entries carry a zero tag; writes are tracked just like reads
    assign push_entry = {sel_src, (sel_src == SRC_D) ? bus.d_req_tag_i : {TAG_W{1'b0}}};
    assign pop        = bus.mem_ack_i && !fifo_empty;
    assign head_src   = head_entry[TAG_W];
    assign head_tag   = head_entry[TAG_W-1:0];

    riscv_mem_arb_fifo #(
        .WIDTH (TAG_W + 1),
        .DEPTH (OUTSTANDING)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (mem_accepted),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Arbitration FSM, locked grant and round-robin pointer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            grant_src_q <= SRC_I;
            rr_q        <= SRC_D;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (flush_take) begin
                        state_q <= ST_FLUSH;
                    end else if (issue && !bus.mem_accept_i) begin
                        state_q     <= ST_HOLD;
                        grant_src_q <= sel_src;
                    end
                end
                ST_HOLD: begin
                    if (bus.mem_accept_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (mem_accepted && both_req) begin
                rr_q <= ~sel_src;
            end
        end
    end

    // Registered response routing: FIFO head picks the destination of each ack;
    // an accepted flush completes locally one cycle later with its own tag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            i_valid_q    <= 1'b0;
            i_error_q    <= 1'b0;
            i_inst_q     <= 32'h0;
            d_ack_q      <= 1'b0;
            d_error_q    <= 1'b0;
            d_data_rd_q  <= 32'h0;
            d_resp_tag_q <= '0;
        end else begin
            i_valid_q    <= pop && (head_src == SRC_I);
            i_error_q    <= (pop && (head_src == SRC_I)) ? bus.mem_error_i : 1'b0;
            i_inst_q     <= (pop && (head_src == SRC_I)) ? bus.mem_data_rd_i : 32'h0;
            d_ack_q      <= (pop && (head_src == SRC_D)) || flush_take;
            d_error_q    <= (pop && (head_src == SRC_D)) ? bus.mem_error_i : 1'b0;
            d_data_rd_q  <= (pop && (head_src == SRC_D)) ? bus.mem_data_rd_i : 32'h0;
            if (flush_take) begin
                d_resp_tag_q <= bus.d_req_tag_i;
            end else if (pop && (head_src == SRC_D)) begin
                d_resp_tag_q <= head_tag;
            end else begin
                d_resp_tag_q <= '0;
            end
        end
    end

    assign bus.i_valid_o    = i_valid_q;
    assign bus.i_error_o    = i_error_q;
    assign bus.i_inst_o     = i_inst_q;
    assign bus.d_ack_o      = d_ack_q;
    assign bus.d_error_o    = d_error_q;
    assign bus.d_data_rd_o  = d_data_rd_q;
    assign bus.d_resp_tag_o = d_resp_tag_q;

endmodule
